// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit.
// Results land in HI/LO on the edge entering FIN; done pulses for one cycle there.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          dz_flag;
  logic          last_step;

  logic signed [WIDTH:0]     mcand;
  logic signed [2*WIDTH+1:0] bsr, bsr_nxt;
  logic signed [WIDTH:0]     acc_sum;

  logic [WIDTH-1:0] b_mag, dq, dq_nxt, dr;
  logic [WIDTH:0]   dr_shift, dr_nxt;
  logic             div_ge, q_neg, r_neg;
  logic             unused_bits;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic             neg);
    return neg ? (~mag + WIDTH'(1)) : mag;
  endfunction

  assign last_step = (cnt == CW'(WIDTH - 1));
  assign busy      = (state == MUL) || (state == DIV);
  assign done      = (state == FIN);
  assign div_zero  = (state == FIN) && dz_flag;

  // Booth step: acc is WIDTH+1 bits so subtracting the most negative multiplicand cannot wrap
  always_comb begin
    acc_sum = bsr[2*WIDTH+1:WIDTH+1];
    case (bsr[1:0])
      2'b01:   acc_sum = bsr[2*WIDTH+1:WIDTH+1] + mcand;
      2'b10:   acc_sum = bsr[2*WIDTH+1:WIDTH+1] - mcand;
      default: ;
    endcase
    bsr_nxt = $signed({acc_sum, bsr[WIDTH:0]}) >>> 1;
  end

  always_comb begin
    dr_shift = {dr, dq[WIDTH-1]};
    div_ge   = (dr_shift >= {1'b0, b_mag});
    dr_nxt   = div_ge ? (dr_shift - {1'b0, b_mag}) : dr_shift;
    dq_nxt   = {dq[WIDTH-2:0], div_ge};
  end

  assign unused_bits = ^{bsr_nxt[2*WIDTH+1], bsr_nxt[0], dr_nxt[WIDTH]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) begin
        if (!op_div)            state_nxt = MUL;
        else if (op_b == '0)    state_nxt = FIN;
        else                    state_nxt = DIV;
      end
      MUL:     if (last_step) state_nxt = FIN;
      DIV:     if (last_step) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      dz_flag <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          cnt     <= '0;
          dz_flag <= op_div && (op_b == '0);
        end
        MUL: begin
          cnt <= cnt + CW'(1);
          if (last_step) {hi, lo} <= bsr_nxt[2*WIDTH:1];
        end
        DIV: begin
          cnt <= cnt + CW'(1);
          if (last_step) begin
            lo <= apply_sign(dq_nxt, q_neg);
            hi <= apply_sign(dr_nxt[WIDTH-1:0], r_neg);
          end
        end
        default: ;
      endcase
    end
  end

  // Iteration datapath: loaded on an accepted start, never reset
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        mcand <= {op_a[WIDTH-1], op_a};
        bsr   <= {{(WIDTH+1){1'b0}}, op_b, 1'b0};
        b_mag <= apply_sign(op_b, op_b[WIDTH-1]);
        dq    <= apply_sign(op_a, op_a[WIDTH-1]);
        dr    <= '0;
        q_neg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
        r_neg <= op_a[WIDTH-1];
      end
      MUL: bsr <= bsr_nxt;
      DIV: begin
        dr <= dr_nxt[WIDTH-1:0];
        dq <= dq_nxt;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, reset/handshake sequences, random ops.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, op_div;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op_div(op_div),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [31:0] a, b;
    logic        dv;
    logic [31:0] eh, el;
    logic        edz;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] m_hi, m_lo;
  logic        m_dz;

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", nm, idx, act, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic; SV division truncates toward zero
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic dv,
                                inout logic [31:0] h, inout logic [31:0] l, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (!dv) begin
      p = sa * sb;
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      p = q;
      l = p[31:0];
      p = r;
      h = p[31:0];
    end
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic dv,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz, input int idx);
    int n;
    int busy_bad;
    logic got;
    op_a = a; op_b = b; op_div = dv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; op_div = 1'($urandom);
    n = 0; busy_bad = 0; got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else if (busy !== 1'b1) busy_bad++;
    end
    chk("latency", idx, 64'(n), edz ? 64'd1 : 64'd33);
    chk("hi", idx, 64'(hi), 64'(eh));
    chk("lo", idx, 64'(lo), 64'(el));
    chk("div_zero", idx, 64'(div_zero), 64'(edz));
    chk("busy_during", idx, 64'(busy_bad), 64'd0);
    chk("busy_at_done", idx, 64'(busy), 64'd0);
    @(negedge clk);
    chk("done_pulse", idx, 64'(done), 64'd0);
  endtask

  initial begin
    int n, d1, d2, cnt_done;
    logic [31:0] a, b;
    logic dv;

    vecs[0] = '{32'hFFFFFFFA, 32'd7,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
    vecs[1] = '{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000001, 1'b0};
    vecs[3] = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4] = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[5] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6] = '{32'h00003412, 32'h00000100, 1'b1, 32'h00000012, 32'h00000034, 1'b0};
    vecs[7] = '{32'd5,        32'd0,        1'b1, 32'h00000012, 32'h00000034, 1'b1};
    vecs[8] = '{32'd7,        32'd3,        1'b0, 32'h00000000, 32'h00000015, 1'b0};

    reset = 1'b0; start = 1'b0; op_div = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, 64'(busy), 64'd0);
    chk("rst_done", 0, 64'(done), 64'd0);
    chk("rst_dz", 0, 64'(div_zero), 64'd0);
    chk("rst_hi", 0, 64'(hi), 64'd0);
    chk("rst_lo", 0, 64'(lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].dv, vecs[i].eh, vecs[i].el, vecs[i].edz, i);

    // Reset in the middle of a MULT: everything cleared, no late done
    op_a = 32'd7; op_b = 32'd3; op_div = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 1, 64'(busy), 64'd0);
    chk("midrst_done", 1, 64'(done), 64'd0);
    chk("midrst_hi", 1, 64'(hi), 64'd0);
    chk("midrst_lo", 1, 64'(lo), 64'd0);
    reset = 1'b1;
    cnt_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    chk("midrst_no_done", 1, 64'(cnt_done), 64'd0);

    m_hi = '0; m_lo = '0;
    for (int i = 0; i < 40; i++) begin
      a  = (i % 5 == 1) ? 32'($urandom_range(0, 50)) : $urandom;
      b  = (i % 7 == 3) ? 32'd0 : ((i % 5 == 2) ? 32'($urandom_range(1, 9)) : $urandom);
      dv = 1'($urandom);
      if (i % 7 == 3) dv = 1'b1;
      model(a, b, dv, m_hi, m_lo, m_dz);
      run_op(a, b, dv, m_hi, m_lo, m_dz, 100 + i);
    end

    // start held high: only IDLE accepts; busy-time operands (incl. a div-by-zero) must be ignored
    op_a = 32'd3; op_b = 32'd5; op_div = 1'b0; start = 1'b1;
    @(posedge clk);
    n = 0; d1 = 0; d2 = 0;
    while (n < 120 && d2 == 0) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (d1 == 0) begin
          d1 = n;
          chk("hs_hi_x", 2, 64'(hi), 64'd0);
          chk("hs_lo_x", 2, 64'(lo), 64'd15);
          chk("hs_dz_x", 2, 64'(div_zero), 64'd0);
        end else begin
          d2 = n;
          chk("hs_hi_y", 2, 64'(hi), 64'd2);
          chk("hs_lo_y", 2, 64'(lo), 64'd14);
          chk("hs_dz_y", 2, 64'(div_zero), 64'd0);
        end
      end
      if (d1 == 0) begin
        if (n % 2 == 1) begin op_a = 32'd5; op_b = 32'd0;  op_div = 1'b1; end
        else            begin op_a = 32'd3; op_b = 32'd5;  op_div = 1'b0; end
      end else begin
        op_a = 32'd100; op_b = 32'd7; op_div = 1'b1;
      end
    end
    start = 1'b0;
    chk("hs_first_done", 2, 64'(d1), 64'd33);
    chk("hs_spacing", 2, 64'(d2 - d1), 64'd34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
